// File: rtl/word_byte_serializer_pkg.sv
// rtl/word_byte_serializer_pkg.sv - shared types, size codes and helpers for the byte store engine.
// Size 2'b11 is folded into the word case everywhere.
package store_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  // Left-justify the bytes to send so the first one sits in [31:24].
  function automatic logic [31:0] size_align(input logic [1:0] size, input logic [31:0] word);
    case (size)
      SIZE_B:  return {word[7:0], 24'h000000};
      SIZE_H:  return {word[15:0], 16'h0000};
      default: return word;
    endcase
  endfunction

endpackage

// File: rtl/word_byte_serializer_if.sv
// rtl/word_byte_serializer_if.sv - store request and byte memory port bundle.
// The slave modport is the serializer; the master modport is the control unit / memory side.
interface word_byte_serializer_if;
  logic        i_start;
  logic [1:0]  i_size;
  logic [31:0] i_word;
  logic [31:0] i_base_addr;
  logic        i_mem_ready;
  logic        o_mem_write;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_data;
  logic        o_busy;
  logic        o_done;

  modport slave (
    input  i_start, i_size, i_word, i_base_addr, i_mem_ready,
    output o_mem_write, o_mem_addr, o_mem_data, o_busy, o_done
  );

  modport master (
    output i_start, i_size, i_word, i_base_addr, i_mem_ready,
    input  o_mem_write, o_mem_addr, o_mem_data, o_busy, o_done
  );
endinterface

// File: rtl/word_byte_serializer_byte_shift_out.sv
// rtl/word_byte_serializer_byte_shift_out.sv - 32-bit shift-left-by-8 register with parallel load.
// Counterpart of the register's shift-load path: the top byte leaves first.
module byte_shift_out (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_load,
  input  logic [31:0] i_data,
  input  logic        i_shift,
  output logic [7:0]  o_byte
);

  logic [31:0] r_shift;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_shift <= 32'h0;
    end else if (i_load) begin
      r_shift <= i_data;
    end else if (i_shift) begin
      r_shift <= {r_shift[23:0], 8'h00};
    end
  end

  assign o_byte = r_shift[31:24];

endmodule

// File: rtl/word_byte_serializer.sv
// rtl/word_byte_serializer.sv - splits a captured word into 1/2/4 bytes written MSB-first at rising addresses.
// Outputs are decoded from state so IDLE and DONE never show stale address or data.
module word_byte_serializer
  import store_pkg::*;
(
  input  logic                  i_clk,
  input  logic                  i_rst,
  word_byte_serializer_if.slave bus
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_addr;
  logic [2:0]  r_count;
  logic        w_load;
  logic        w_handshake;
  logic [7:0]  w_byte;
  logic        w_mem_write;
  logic [31:0] w_mem_addr;
  logic [7:0]  w_mem_data;
  logic        w_busy;
  logic        w_done;

  byte_shift_out u_shift (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_load (w_load),
    .i_data (size_align(bus.i_size, bus.i_word)),
    .i_shift(w_handshake),
    .o_byte (w_byte)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_addr  <= 32'h0;
      r_count <= 3'd0;
    end else begin
      r_state <= w_next_state;
      if (w_load) begin
        r_addr  <= bus.i_base_addr;
        r_count <= size_bytes(bus.i_size);
      end else if (w_handshake) begin
        r_addr  <= r_addr + 32'd1;
        r_count <= r_count - 3'd1;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_handshake  = 1'b0;
    w_mem_write  = 1'b0;
    w_mem_addr   = 32'h0;
    w_mem_data   = 8'h00;
    w_busy       = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.i_start) begin
          w_load       = 1'b1;
          w_next_state = SEND;
        end
      end
      SEND: begin
        w_mem_write = 1'b1;
        w_mem_addr  = r_addr;
        w_mem_data  = w_byte;
        w_busy      = 1'b1;
        w_handshake = bus.i_mem_ready;
        if (bus.i_mem_ready && (r_count == 3'd1)) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_done       = 1'b1;
        w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  assign bus.o_mem_write = w_mem_write;
  assign bus.o_mem_addr  = w_mem_addr;
  assign bus.o_mem_data  = w_mem_data;
  assign bus.o_busy      = w_busy;
  assign bus.o_done      = w_done;

endmodule

// File: tb/tb_word_byte_serializer.sv
// tb/tb_word_byte_serializer.sv - directed vector table plus reset and start-while-busy sequences.
module tb_word_byte_serializer;

  typedef struct {
    logic [1:0]  size;
    logic [31:0] word;
    logic [31:0] base;
    int          n;
    logic [31:0] bytes;
    int          stall;
  } vec_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  vec_t vecs[6];

  word_byte_serializer_if bus ();

  word_byte_serializer dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_byte(input logic [31:0] addr, input logic [7:0] data);
    check("send_mem_write", {31'b0, bus.o_mem_write}, 32'd1);
    check("send_busy", {31'b0, bus.o_busy}, 32'd1);
    check("send_done", {31'b0, bus.o_done}, 32'd0);
    check("send_addr", bus.o_mem_addr, addr);
    check("send_data", {24'b0, bus.o_mem_data}, {24'b0, data});
  endtask

  task automatic check_quiet(input string name, input logic done);
    check({name, "_done"}, {31'b0, bus.o_done}, {31'b0, done});
    check({name, "_mem_write"}, {31'b0, bus.o_mem_write}, 32'd0);
    check({name, "_busy"}, {31'b0, bus.o_busy}, 32'd0);
    check({name, "_addr"}, bus.o_mem_addr, 32'd0);
    check({name, "_data"}, {24'b0, bus.o_mem_data}, 32'd0);
  endtask

  task automatic start_store(input logic [1:0] size, input logic [31:0] word, input logic [31:0] base);
    bus.i_start     = 1'b1;
    bus.i_size      = size;
    bus.i_word      = word;
    bus.i_base_addr = base;
    @(negedge clk);
    bus.i_start     = 1'b0;
    bus.i_size      = 2'b00;
    bus.i_word      = 32'h55AA_33CC;
    bus.i_base_addr = 32'h0BAD_0000;
  endtask

  task automatic run_store(input vec_t v);
    logic [31:0] b;
    b = v.bytes;
    start_store(v.size, v.word, v.base);
    for (int i = 0; i < v.n; i++) begin
      if (i == 0) begin
        for (int s = 0; s < v.stall; s++) begin
          bus.i_mem_ready = 1'b0;
          check_byte(v.base, b[31:24]);
          @(negedge clk);
        end
      end
      bus.i_mem_ready = 1'b1;
      check_byte(v.base + 32'(i), b[31:24]);
      b = b << 8;
      @(negedge clk);
    end
    bus.i_mem_ready = 1'b0;
    check_quiet("done", 1'b1);
    @(negedge clk);
    check_quiet("idle", 1'b0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    vecs[0] = '{2'b10, 32'hDEADBEEF, 32'h0000_0100, 4, 32'hDEADBEEF, 0};
    vecs[1] = '{2'b01, 32'h1234ABCD, 32'h0000_0020, 2, 32'hABCD0000, 2};
    vecs[2] = '{2'b00, 32'hFFFFFF5A, 32'h0000_0040, 1, 32'h5A000000, 0};
    vecs[3] = '{2'b10, 32'h01234567, 32'hFFFF_FFFE, 4, 32'h01234567, 0};
    vecs[4] = '{2'b11, 32'hCAFEF00D, 32'h0000_0007, 4, 32'hCAFEF00D, 1};
    vecs[5] = '{2'b01, 32'h9876_5432, 32'h8000_0000, 2, 32'h54320000, 0};

    rst             = 1'b1;
    bus.i_start     = 1'b0;
    bus.i_size      = 2'b00;
    bus.i_word      = 32'h0;
    bus.i_base_addr = 32'h0;
    bus.i_mem_ready = 1'b1;
    repeat (2) @(negedge clk);
    check_quiet("reset", 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("post_reset_ready_ignored", 1'b0);
    bus.i_mem_ready = 1'b0;

    for (int k = 0; k < 6; k++) begin
      run_store(vecs[k]);
    end

    // Reset after two of four bytes have been accepted.
    start_store(2'b10, 32'hA1B2C3D4, 32'h0000_0200);
    bus.i_mem_ready = 1'b1;
    check_byte(32'h0000_0200, 8'hA1);
    @(negedge clk);
    check_byte(32'h0000_0201, 8'hB2);
    @(negedge clk);
    check_byte(32'h0000_0202, 8'hC3);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_quiet("mid_reset", 1'b0);
    @(negedge clk);
    check_quiet("mid_reset_no_done", 1'b0);
    bus.i_mem_ready = 1'b0;
    run_store(vecs[0]);

    // Start pulses during SEND and DONE must be dropped.
    start_store(2'b10, 32'h1122_3344, 32'h0000_0300);
    bus.i_mem_ready = 1'b1;
    check_byte(32'h0000_0300, 8'h11);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_size  = 2'b00;
    bus.i_word  = 32'h0000_00EE;
    bus.i_base_addr = 32'h0000_0900;
    check_byte(32'h0000_0301, 8'h22);
    @(negedge clk);
    bus.i_start = 1'b0;
    check_byte(32'h0000_0302, 8'h33);
    @(negedge clk);
    check_byte(32'h0000_0303, 8'h44);
    @(negedge clk);
    bus.i_start = 1'b1;
    bus.i_word  = 32'h0000_00DD;
    check_quiet("busy_done", 1'b1);
    @(negedge clk);
    bus.i_start = 1'b0;
    check_quiet("busy_idle", 1'b0);
    @(negedge clk);
    check_quiet("busy_no_restart", 1'b0);
    bus.i_mem_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
